// File: rtl/div_unit_iter_pkg.sv
// Shared definitions for the iterative divider: op encodings, FSM states and constants.
package div_unit_iter_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam int          DIV_ITER      = 32;
  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

endpackage

// File: rtl/div_unit_iter_cla.sv
// Carry-look-ahead adder/subtractor: 4-bit lookahead groups with rippled group carries.
module CarryLookAheadAdder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_mode,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  logic [WIDTH-1:0]   w_b;
  logic [WIDTH-1:0]   w_g;
  logic [WIDTH-1:0]   w_p;
  logic [WIDTH/4:0]   w_c;

  // mode=1 inverts b so that with cin=1 the adder computes a - b
  assign w_b    = i_b ^ {WIDTH{i_mode}};
  assign w_g    = i_a & w_b;
  assign w_p    = i_a ^ w_b;
  assign w_c[0] = i_cin;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH/4; gi++) begin : g_grp
      logic [3:0] w_gg;
      logic [3:0] w_pp;
      logic [4:0] w_cc;
      assign w_gg    = w_g[4*gi +: 4];
      assign w_pp    = w_p[4*gi +: 4];
      assign w_cc[0] = w_c[gi];
      assign w_cc[1] = w_gg[0] | (w_pp[0] & w_cc[0]);
      assign w_cc[2] = w_gg[1] | (w_pp[1] & w_gg[0]) | (w_pp[1] & w_pp[0] & w_cc[0]);
      assign w_cc[3] = w_gg[2] | (w_pp[2] & w_gg[1]) | (w_pp[2] & w_pp[1] & w_gg[0])
                     | (w_pp[2] & w_pp[1] & w_pp[0] & w_cc[0]);
      assign w_cc[4] = w_gg[3] | (w_pp[3] & w_gg[2]) | (w_pp[3] & w_pp[2] & w_gg[1])
                     | (w_pp[3] & w_pp[2] & w_pp[1] & w_gg[0])
                     | (w_pp[3] & w_pp[2] & w_pp[1] & w_pp[0] & w_cc[0]);
      assign o_sum[4*gi +: 4] = w_pp ^ w_cc[3:0];
      assign w_c[gi+1]        = w_cc[4];
    end
  endgenerate

  assign o_cout = w_c[WIDTH/4];

endmodule

// File: rtl/div_unit_iter.sv
// Iterative restoring divider (DIV/DIVU/REM/REMU), one quotient bit per clock.
// Signed DIV/REM support is enabled by defining DIV_SIGNED_EN; otherwise they act as DIVU/REMU.
module div_unit_iter
  import div_unit_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [4:0]       rd_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       out_tag,
  output logic             busy
);

  localparam logic [4:0] LAST_CNT = 5'(ITER - 1);

  state_e           r_state;
  state_e           w_state_next;
  logic             r_sel_rem;
  logic [4:0]       r_tag;
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_dvsr;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [4:0]       r_cnt;
  logic [WIDTH-1:0] r_result;
  logic [4:0]       r_out_tag;

  logic [WIDTH:0]   w_shifted;
  logic [WIDTH-1:0] w_diff;
  logic             w_cout;
  logic             w_ok;
  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;
  logic             w_div_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_state_next = PREP;
      end
      PREP: w_state_next = CALC;
      CALC: if (r_cnt == LAST_CNT) w_state_next = FIX;
      FIX:  w_state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    // flush overrides everything, including a retiring out_ready
    if (flush) w_state_next = IDLE;
  end

  assign w_shifted = {r_rem, r_quo[WIDTH-1]};
  assign w_ok      = w_shifted[WIDTH] | w_cout;
  assign w_div_zero = (r_divisor == '0);

  CarryLookAheadAdder #(.WIDTH(WIDTH)) u_sub (
    .i_a    (w_shifted[WIDTH-1:0]),
    .i_b    (r_dvsr),
    .i_mode (1'b1),
    .i_cin  (1'b1),
    .o_sum  (w_diff),
    .o_cout (w_cout)
  );

`ifdef DIV_SIGNED_EN
  logic r_signed;
  logic r_neg_q;
  logic r_neg_r;
  logic w_a_neg;
  logic w_b_neg;

  assign w_a_neg   = r_signed & r_dividend[WIDTH-1];
  assign w_b_neg   = r_signed & r_divisor[WIDTH-1];
  assign w_a_abs   = w_a_neg ? neg32(r_dividend) : r_dividend;
  assign w_b_abs   = w_b_neg ? neg32(r_divisor)  : r_divisor;
  assign w_quo_fix = w_div_zero ? DIV_BY_ZERO_Q : (r_neg_q ? neg32(r_quo) : r_quo);
  assign w_rem_fix = w_div_zero ? r_dividend    : (r_neg_r ? neg32(r_rem) : r_rem);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_signed <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (r_state == IDLE && in_valid) begin
      r_signed <= ~op[0];
    end else if (r_state == PREP) begin
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
    end
  end
`else
  assign w_a_abs   = r_dividend;
  assign w_b_abs   = r_divisor;
  assign w_quo_fix = w_div_zero ? DIV_BY_ZERO_Q : r_quo;
  assign w_rem_fix = w_div_zero ? r_dividend    : r_rem;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_rem  <= 1'b0;
      r_tag      <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_dvsr     <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_cnt      <= '0;
      r_result   <= '0;
      r_out_tag  <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_sel_rem  <= op[1];
          r_tag      <= rd_tag;
          r_dividend <= dividend;
          r_divisor  <= divisor;
        end
        PREP: begin
          r_rem  <= '0;
          r_quo  <= w_a_abs;
          r_dvsr <= w_b_abs;
          r_cnt  <= '0;
        end
        CALC: begin
          r_rem <= w_ok ? w_diff : w_shifted[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], w_ok};
          r_cnt <= r_cnt + 5'd1;
        end
        FIX: begin
          r_result  <= r_sel_rem ? w_rem_fix : w_quo_fix;
          r_out_tag <= r_tag;
        end
        default: ;
      endcase
    end
  end

  assign result  = r_result;
  assign out_tag = r_out_tag;

endmodule

// File: doc/div_unit_iter.md
# div_unit_iter

Iterative 32-bit integer divider for the execute stage, covering DIV, DIVU, REM and REMU. It sits beside the ALU and sends every trial subtraction through the 32-bit carry-look-ahead adder in subtract mode, one quotient bit per clock. Operands arrive on a valid/ready handshake from decode/issue. The result leaves on a valid/ready handshake to writeback.

## Interface
Parameters:
- WIDTH, 32: operand and result width. Only 32 is supported.
- ITER, 32: iteration count. Must equal WIDTH.

Ports:
- clk  in  1  rising-edge clock, the only clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- flush  in  1  synchronous abort from pipeline control.
- in_valid  in  1  operands valid.
- in_ready  out  1  unit can accept operands.
- op  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend  in  32  rs1.
- divisor  in  32  rs2.
- rd_tag  in  5  destination register index, carried through unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  writeback accepts the result.
- result  out  32  quotient or remainder, selected by op.
- out_tag  out  5  rd_tag of the operation that produced result.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states and transitions:
  - IDLE → PREP on accept (in_valid & in_ready).
  - PREP → CALC.
  - CALC → FIX when the 5-bit counter reaches 31.
  - FIX → DONE.
  - DONE → IDLE on out_ready.
- in_ready = 1 only in IDLE.
- Accept: latch op, rd_tag, dividend and divisor.
- PREP:
  - Signed ops: take absolute values of both operands; record neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend).
  - Unsigned ops: neg_q = neg_r = 0.
  - Clear rem[31:0]; load quo with |dividend|; clear the counter.
- CALC, each cycle:
  - shifted = {rem, quo[31]}, 33 bits.
  - The adder computes shifted[31:0] − |divisor| (mode=1, cin=1).
  - Subtraction succeeds when shifted[32] | cout.
  - On success: rem ← difference and quo ← {quo[30:0],1}.
  - Otherwise: rem ← shifted[31:0] and quo ← {quo[30:0],0}.
- FIX:
  - Divisor == 0: quotient = 0xFFFF_FFFF, remainder = original dividend, no sign correction.
  - Otherwise: negate quo if neg_q; negate rem if neg_r.
  - Overflow 0x8000_0000 / 0xFFFF_FFFF (DIV/REM) needs no special case. It yields quotient 0x8000_0000 and remainder 0 naturally.
  - Register result (quo for op[1]=0, rem for op[1]=1) and out_tag.
- DONE:
  - out_valid = 1.
  - result and out_tag hold stable until out_ready.
  - out_ready in the same cycle as out_valid retires the result; the unit is back in IDLE the next cycle.
- flush in any state → IDLE next cycle, with out_valid = 0. A pending result is discarded.
- flush wins over simultaneous out_ready.

## Timing
- Reset values: in_ready = 1, out_valid = 0, busy = 0, result = 0, out_tag = 0, state = IDLE, all datapath registers = 0.
- Reset is asynchronous and active-low (rst_n); it aborts any operation mid-flight.
- Cycle timing from an accept at rising edge T:
  - PREP during T..T+1.
  - CALC occupies 32 cycles.
  - FIX, then out_valid rises after edge T+34.
  - Fixed latency of 34 cycles, independent of operand values.
- No back-to-back accept: the earliest next accept is the cycle after DONE retires.
- Throughput: one operation per 35 cycles minimum.
- Operands may change after accept without affecting the operation in flight.

## Configuration
- DIV_SIGNED_EN defined: DIV and REM are fully signed as specified above.
- DIV_SIGNED_EN undefined:
  - The PREP absolute-value logic and the FIX negators are compiled out.
  - neg_q and neg_r are tied to 0.
  - DIV behaves as DIVU and REM behaves as REMU.
  - Divide-by-zero results are unchanged.

## Structure
- Shared package holds:
  - the op encodings (OP_DIV, OP_DIVU, OP_REM, OP_REMU);
  - the state enum (IDLE, PREP, CALC, FIX, DONE);
  - the constants DIV_ITER = 32 and DIV_BY_ZERO_Q = 32'hFFFF_FFFF.
- Sub-module: CarryLookAheadAdder, one instance with WIDTH = 32, used as the trial subtractor.
- Negation in FIX uses ~x + 1 inline; it is not a second adder instance.

## Test plan
- DIVU 100 / 7 → result 14 with out_valid exactly 34 cycles after accept. REMU 100 / 7 → 2.
- DIV −7 / 2 → 0xFFFF_FFFD (−3). REM −7 / 2 → 0xFFFF_FFFF (−1). REM 7 / −2 → 1.
- DIVU 0x1234 / 0 → 0xFFFF_FFFF. REM −5 / 0 → 0xFFFF_FFFB.
- DIV 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000. REM of the same operands → 0.
- Hold out_ready low for 10 cycles in DONE → result and out_tag stable, in_ready = 0. Then raise out_ready → in_ready = 1 the next cycle.
- Assert flush at CALC cycle 10, or drop rst_n mid-CALC → IDLE with out_valid = 0. A following DIVU 9 / 3 → 3.
